slice_serial_adder: RTL and testbench



---
 rtl/adder_pkg.sv | 13 +
 rtl/adder_slice.sv | 31 +++
 rtl/full_adder.sv | 13 +
 rtl/slice_serial_adder.sv | 136 +++++++++++++
 tb/tb_slice_serial_adder.sv | 170 +++++++++++++++++
 5 files changed

// File: rtl/adder_pkg.sv
// Shared definitions for the serial adder: FSM state encoding and op-mode constants.
package adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/adder_slice.sv
// Combinational SLICE-bit ripple adder built from full_adder cells.
// Also exposes the carry into the slice MSB so the top can derive signed overflow.
module adder_slice #(
    parameter int SLICE = 4
) (
    input  logic [SLICE-1:0] a_i,
    input  logic [SLICE-1:0] b_i,
    input  logic             c_i,
    output logic [SLICE-1:0] s_o,
    output logic             c_o,
    output logic             c_msb_o
);

    logic [SLICE:0] carry;

    assign carry[0] = c_i;

    for (genvar gi = 0; gi < SLICE; gi++) begin : g_bit
        full_adder u_fa (
            .a_i (a_i[gi]),
            .b_i (b_i[gi]),
            .c_i (carry[gi]),
            .s_o (s_o[gi]),
            .c_o (carry[gi+1])
        );
    end

    assign c_o     = carry[SLICE];
    assign c_msb_o = carry[SLICE-1];

endmodule

// File: rtl/full_adder.sv
// One-bit full adder cell, the building block of the ripple slice.
module full_adder (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic s_o,
    output logic c_o
);

    assign s_o = a_i ^ b_i ^ c_i;
    assign c_o = (a_i & b_i) | (c_i & (a_i ^ b_i));

endmodule

// File: rtl/slice_serial_adder.sv
// Multi-cycle add/subtract: one SLICE-bit ripple slice reused NSLICE times,
// carry held in a register, valid/ready on both sides.
module slice_serial_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SLICE = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NSLICE = (SLICE < 1) ? 1 : WIDTH / SLICE;
    localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [CW-1:0] LAST = CW'(NSLICE - 1);

    if (SLICE < 1) begin : g_chk_slice
        $fatal(1, "slice_serial_adder: SLICE must be at least 1");
    end else if ((WIDTH % SLICE) != 0) begin : g_chk_width
        $fatal(1, "slice_serial_adder: WIDTH must be a multiple of SLICE");
    end

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic [SLICE-1:0] s_sum;
    logic             s_cout;
    logic             s_cmsb;
    logic [WIDTH-1:0] slice_ext;

    adder_slice #(.SLICE(SLICE)) u_slice (
        .a_i     (a_q[SLICE-1:0]),
        .b_i     (b_q[SLICE-1:0]),
        .c_i     (carry_q),
        .s_o     (s_sum),
        .c_o     (s_cout),
        .c_msb_o (s_cmsb)
    );

    assign slice_ext = WIDTH'(s_sum);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        a_d       = a_q;
        b_d       = b_q;
        res_d     = res_q;
        carry_d   = carry_q;
        sum_d     = sum_q;
        cout_d    = cout_q;
        ovf_d     = ovf_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;

        case (state_q)
            IDLE: begin
                in_ready = !rst;
                if (in_valid) begin
                    state_d = RUN;
                    a_d     = a;
                    b_d     = (sub == OP_SUB) ? ~b : b;
                    carry_d = (sub == OP_SUB) ? 1'b1 : cin;
                    cnt_d   = '0;
                end
            end
            RUN: begin
                // Result fills from the top so the last slice lands in the MSBs.
                res_d   = (res_q >> SLICE) | (slice_ext << (WIDTH - SLICE));
                a_d     = a_q >> SLICE;
                b_d     = b_q >> SLICE;
                carry_d = s_cout;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    sum_d   = res_d;
                    cout_d  = s_cout;
                    ovf_d   = s_cmsb ^ s_cout;
                    state_d = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            carry_q <= carry_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_slice_serial_adder.sv
// Directed bench for slice_serial_adder: a 16/4 instance and an 8/8 instance.
module tb_slice_serial_adder;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // 16-bit, 4-bit slice instance
    logic        iv16, ir16, ov16, or16, cin16, sub16, co16, of16;
    logic [15:0] a16, b16, s16;

    // 8-bit, single slice instance
    logic        iv8, ir8, ov8, or8, cin8, sub8, co8, of8;
    logic [7:0]  a8, b8, s8;

    int n_vec  = 0;
    int n_miss = 0;

    slice_serial_adder #(.WIDTH(16), .SLICE(4)) dut16 (
        .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(ir16),
        .a(a16), .b(b16), .cin(cin16), .sub(sub16),
        .out_valid(ov16), .out_ready(or16), .sum(s16), .cout(co16), .ovf(of16)
    );

    slice_serial_adder #(.WIDTH(8), .SLICE(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8),
        .a(a8), .b(b8), .cin(cin8), .sub(sub8),
        .out_valid(ov8), .out_ready(or8), .sum(s8), .cout(co8), .ovf(of8)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one bundle on dut16 and wait for the accepting edge.
    task automatic start16(input logic [15:0] ta, input logic [15:0] tb, input logic tc, input logic ts);
        int guard = 0;
        while (!ir16 && guard < 20) begin
            tick();
            guard++;
        end
        chk("start_ready", 32'(ir16), 32'd1);
        a16 = ta; b16 = tb; cin16 = tc; sub16 = ts; iv16 = 1'b1;
        tick();
        iv16 = 1'b0;
    endtask

    // Count edges after the accept until out_valid, then check the result.
    task automatic finish16(input string tag, input logic [15:0] es, input logic ec, input logic eo);
        int lat = 0;
        while (!ov16 && lat < 20) begin
            tick();
            lat++;
        end
        chk({tag, "_lat"},  32'(lat),  32'd4);
        chk({tag, "_sum"},  32'(s16),  32'(es));
        chk({tag, "_cout"}, 32'(co16), 32'(ec));
        chk({tag, "_ovf"},  32'(of16), 32'(eo));
    endtask

    task automatic release16(input string tag);
        or16 = 1'b1;
        tick();
        or16 = 1'b0;
        chk({tag, "_rel_ov"}, 32'(ov16), 32'd0);
        chk({tag, "_rel_ir"}, 32'(ir16), 32'd1);
    endtask

    task automatic op16(input string tag, input logic [15:0] ta, input logic [15:0] tb,
                        input logic tc, input logic ts,
                        input logic [15:0] es, input logic ec, input logic eo);
        start16(ta, tb, tc, ts);
        finish16(tag, es, ec, eo);
        release16(tag);
    endtask

    initial begin
        logic [15:0] held;
        int lat8;
        bit saw_ov;

        rst = 1'b1;
        iv16 = 0; or16 = 0; a16 = 0; b16 = 0; cin16 = 0; sub16 = 0;
        iv8 = 0;  or8 = 0;  a8 = 0;  b8 = 0;  cin8 = 0;  sub8 = 0;
        tick();
        tick();
        chk("rst_in_ready", 32'(ir16), 32'd0);
        chk("rst_out_valid", 32'(ov16), 32'd0);
        chk("rst_sum", 32'(s16), 32'd0);
        chk("rst_cout", 32'(co16), 32'd0);
        rst = 1'b0;
        #1;
        chk("idle_in_ready", 32'(ir16), 32'd1);

        op16("add_basic",   16'h1234, 16'h1111, 1'b0, 1'b0, 16'h2345, 1'b0, 1'b0);
        op16("wrap_b1",     16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        op16("wrap_cin",    16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
        op16("ovf_add",     16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
        op16("ovf_sub",     16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
        op16("sub_borrow",  16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);

        // Backpressure: hold DONE for 5 cycles while a new bundle is offered.
        start16(16'h0F0F, 16'h00F1, 1'b0, 1'b0);
        finish16("bp", 16'h1000, 1'b0, 1'b0);
        held = s16;
        a16 = 16'h1111; b16 = 16'h2222; iv16 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("bp_ov_%0d", i), 32'(ov16), 32'd1);
            chk($sformatf("bp_sum_%0d", i), 32'(s16), 32'(held));
            chk($sformatf("bp_ir_%0d", i), 32'(ir16), 32'd0);
        end
        iv16 = 1'b0;
        release16("bp");
        chk("bp_hold_sum", 32'(s16), 32'h1000);

        // Abort mid-RUN after two slice cycles.
        start16(16'h4321, 16'h1234, 1'b0, 1'b0);
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("abort_ov", 32'(ov16), 32'd0);
        chk("abort_ir", 32'(ir16), 32'd1);
        chk("abort_sum", 32'(s16), 32'd0);
        saw_ov = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (ov16) saw_ov = 1'b1;
        end
        chk("abort_no_result", 32'(saw_ov), 32'd0);
        op16("post_abort", 16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0);

        // Single-slice instance: one RUN cycle.
        chk("w8_ir", 32'(ir8), 32'd1);
        a8 = 8'h7F; b8 = 8'h01; cin8 = 1'b0; sub8 = 1'b0; iv8 = 1'b1;
        tick();
        iv8 = 1'b0;
        lat8 = 0;
        while (!ov8 && lat8 < 20) begin
            tick();
            lat8++;
        end
        chk("w8_lat", 32'(lat8), 32'd1);
        chk("w8_sum", 32'(s8), 32'h80);
        chk("w8_cout", 32'(co8), 32'd0);
        chk("w8_ovf", 32'(of8), 32'd1);
        or8 = 1'b1;
        tick();
        or8 = 1'b0;
        chk("w8_rel_ir", 32'(ir8), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
